// File: rtl/safe_zone_ctrl.sv
// safe_zone_ctrl
// Builds each level's horizontal safe zone and judges the level outcome.
// A regenerate request sizes the zone from the current rating, places it with
// an LFSR-driven candidate (falling back to the right edge after repeated
// rejects), then pulses o_ready. While the game runs it pulses o_is_win once
// the player has held inside the zone long enough, or o_is_lose when the
// level timer runs out.
module safe_zone_ctrl #(
    parameter int COORD_WIDTH  = 10,
    parameter int SCREEN_W     = 640,
    parameter int RATING_WIDTH = 8,
    parameter int ZONE_MAX_W   = 128,
    parameter int ZONE_MIN_W   = 16,
    parameter int SHRINK_STEP  = 8,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int LEVEL_CYCLES = 500_000_000,
    parameter int MAX_TRIES    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_regenerate_level,
    input  logic [RATING_WIDTH-1:0]           i_current_rating,
    input  logic                              i_game_running,
    input  logic [COORD_WIDTH-1:0]            i_player_x,
    output logic                              o_ready,
    output logic                              o_is_win,
    output logic                              o_is_lose,
    output logic [COORD_WIDTH-1:0]            o_zone_left,
    output logic [COORD_WIDTH-1:0]            o_zone_right,
    output logic [$clog2(LEVEL_CYCLES+1)-1:0] o_time_left
);

    localparam int TIME_W  = $clog2(LEVEL_CYCLES + 1);
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int WIDTH_W = COORD_WIDTH + 1;

    localparam logic [TIME_W-1:0] TIME_LOAD = TIME_W'(LEVEL_CYCLES);
    localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_TRIES - 1);
    localparam logic [TRY_W-1:0]  TRY_ONE   = TRY_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIZE,
        ST_PLACE,
        ST_READY,
        ST_ARMED,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [WIDTH_W-1:0]     width_q, width_d;
    logic [TRY_W-1:0]       try_q, try_d;
    logic [COORD_WIDTH-1:0] zone_left_q, zone_left_d;
    logic [COORD_WIDTH-1:0] zone_right_q, zone_right_d;
    logic [TIME_W-1:0]      time_left_q, time_left_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   win_q, win_d;
    logic                   lose_q, lose_d;

    logic [31:0]            shrink_amt;
    logic [31:0]            size_width;
    logic [31:0]            cand_end;
    logic                   cand_fits;
    logic                   player_in;

    // Zone width from the rating, at 32-bit precision so large ratings clamp
    // to the minimum instead of wrapping.
    always_comb begin
        shrink_amt = 32'(i_current_rating) * 32'(SHRINK_STEP);
        if (shrink_amt + 32'(ZONE_MIN_W) >= 32'(ZONE_MAX_W)) begin
            size_width = 32'(ZONE_MIN_W);
        end else begin
            size_width = 32'(ZONE_MAX_W) - shrink_amt;
        end
    end

    // Candidate placement test and player-in-zone test.
    always_comb begin
        cand_end  = 32'(lfsr_q[COORD_WIDTH-1:0]) + 32'(width_q);
        cand_fits = (cand_end <= 32'(SCREEN_W));
        player_in = (i_player_x >= zone_left_q) && (i_player_x <= zone_right_q);
    end

    // Next-state and datapath updates; defaults hold every register.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        width_d      = width_q;
        try_d        = try_q;
        zone_left_d  = zone_left_q;
        zone_right_d = zone_right_q;
        time_left_d  = time_left_q;
        hold_d       = hold_q;
        win_d        = 1'b0;
        lose_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_regenerate_level) begin
                    state_d = ST_SIZE;
                end
            end

            ST_SIZE: begin
                // Rating is sampled here, one cycle after the request, since
                // the rating source changes on the same edge as the request.
                width_d = WIDTH_W'(size_width);
                try_d   = '0;
                state_d = ST_PLACE;
            end

            ST_PLACE: begin
                if (cand_fits) begin
                    zone_left_d  = lfsr_q[COORD_WIDTH-1:0];
                    zone_right_d = COORD_WIDTH'(cand_end - 32'd1);
                    time_left_d  = TIME_LOAD;
                    hold_d       = '0;
                    state_d      = ST_READY;
                end else if (try_q == TRY_LAST) begin
                    // Out of attempts: pin the zone against the right edge.
                    zone_left_d  = COORD_WIDTH'(32'(SCREEN_W) - 32'(width_q));
                    zone_right_d = COORD_WIDTH'(SCREEN_W - 1);
                    time_left_d  = TIME_LOAD;
                    hold_d       = '0;
                    state_d      = ST_READY;
                end else begin
                    try_d = try_q + TRY_ONE;
                end
            end

            ST_READY: begin
                if (i_regenerate_level) begin
                    state_d = ST_SIZE;
                end else begin
                    state_d = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (i_regenerate_level) begin
                    // Abort the running level silently.
                    state_d = ST_SIZE;
                end else if (i_game_running) begin
                    if (player_in && (hold_q == HOLD_LAST)) begin
                        win_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (time_left_q == TIME_ONE) begin
                        lose_d      = 1'b1;
                        time_left_d = '0;
                        state_d     = ST_DONE;
                    end else begin
                        if (time_left_q != '0) begin
                            time_left_d = time_left_q - TIME_ONE;
                        end
                        hold_d = player_in ? (hold_q + HOLD_ONE) : '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= 16'hACE1;
            width_q      <= '0;
            try_q        <= '0;
            zone_left_q  <= '0;
            zone_right_q <= '0;
            time_left_q  <= '0;
            hold_q       <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            width_q      <= width_d;
            try_q        <= try_d;
            zone_left_q  <= zone_left_d;
            zone_right_q <= zone_right_d;
            time_left_q  <= time_left_d;
            hold_q       <= hold_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
        end
    end

    assign o_ready      = (state_q == ST_READY);
    assign o_is_win     = win_q;
    assign o_is_lose    = lose_q;
    assign o_zone_left  = zone_left_q;
    assign o_zone_right = zone_right_q;
    assign o_time_left  = time_left_q;

endmodule

// File: tb/tb_safe_zone_ctrl.sv
// Directed testbench for safe_zone_ctrl with a short level and hold time.
module tb_safe_zone_ctrl;

    localparam int CW = 10;
    localparam int RW = 8;
    localparam int LC = 100;
    localparam int HC = 10;
    localparam int TW = $clog2(LC + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_regenerate_level;
    logic [RW-1:0] i_current_rating;
    logic          i_game_running;
    logic [CW-1:0] i_player_x;
    logic          o_ready;
    logic          o_is_win;
    logic          o_is_lose;
    logic [CW-1:0] o_zone_left;
    logic [CW-1:0] o_zone_right;
    logic [TW-1:0] o_time_left;

    int n_checks = 0;
    int n_fail   = 0;

    safe_zone_ctrl #(
        .HOLD_CYCLES  (HC),
        .LEVEL_CYCLES (LC)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_regenerate_level (i_regenerate_level),
        .i_current_rating   (i_current_rating),
        .i_game_running     (i_game_running),
        .i_player_x         (i_player_x),
        .o_ready            (o_ready),
        .o_is_win           (o_is_win),
        .o_is_lose          (o_is_lose),
        .o_zone_left        (o_zone_left),
        .o_zone_right       (o_zone_right),
        .o_time_left        (o_time_left)
    );

    always #5 clk = ~clk;

    // Advance one clock; observe 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a regenerate request (rating req_r on the request cycle, size_r
    // afterwards) and wait for o_ready; lat is cycles after request, -1 on timeout.
    task automatic start_level(input logic [RW-1:0] req_r, input logic [RW-1:0] size_r,
                               output int lat);
        i_regenerate_level = 1'b1;
        i_current_rating   = req_r;
        tick();
        i_regenerate_level = 1'b0;
        i_current_rating   = size_r;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (o_ready === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [CW-1:0] outside_x(input logic [CW-1:0] zl, input logic [CW-1:0] zr);
        if (zl != '0) return '0;
        return zr + 10'd1;
    endfunction

    task automatic test_reset();
        n_checks++;
        if (o_ready !== 1'b0 || o_is_win !== 1'b0 || o_is_lose !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: ready=%b win=%b lose=%b, required all 0", o_ready, o_is_win, o_is_lose);
        end
        n_checks++;
        if (o_zone_left !== '0 || o_zone_right !== '0 || o_time_left !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: left=%0d right=%0d time=%0d, required 0 0 0", o_zone_left, o_zone_right, o_time_left);
        end
        $display("test_reset: done");
    endtask

    task automatic test_regen();
        int lat;
        start_level(8'd0, 8'd0, lat);
        n_checks++;
        if (lat < 3 || lat > 10) begin
            n_fail++;
            $display("FAIL ready_latency: got %0d, required 3..10", lat);
        end
        n_checks++;
        if (int'(o_zone_right) - int'(o_zone_left) != 127) begin
            n_fail++;
            $display("FAIL width_rating0: right-left=%0d, required 127", int'(o_zone_right) - int'(o_zone_left));
        end
        n_checks++;
        if (o_zone_right > 10'd639) begin
            n_fail++;
            $display("FAIL zone_in_screen: right=%0d, required <= 639", o_zone_right);
        end
        n_checks++;
        if (o_time_left !== TW'(LC)) begin
            n_fail++;
            $display("FAIL time_load: got %0d, required %0d", o_time_left, LC);
        end
        tick();
        n_checks++;
        if (o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_one_cycle: ready=%b on next cycle, required 0", o_ready);
        end
        $display("test_regen: latency=%0d left=%0d right=%0d", lat, o_zone_left, o_zone_right);
    endtask

    task automatic test_width(input logic [RW-1:0] req_r, input logic [RW-1:0] size_r, input int exp_w);
        int lat;
        start_level(req_r, size_r, lat);
        n_checks++;
        if (lat < 3 || lat > 10) begin
            n_fail++;
            $display("FAIL width_latency: rating %0d got %0d, required 3..10", size_r, lat);
        end
        n_checks++;
        if (int'(o_zone_right) - int'(o_zone_left) + 1 != exp_w || o_zone_right > 10'd639) begin
            n_fail++;
            $display("FAIL zone_width: rating %0d left=%0d right=%0d, required width %0d within 0..639",
                     size_r, o_zone_left, o_zone_right, exp_w);
        end
        tick();
        $display("test_width: rating=%0d left=%0d right=%0d", size_r, o_zone_left, o_zone_right);
    endtask

    task automatic test_win();
        int lat;
        logic [CW-1:0] zl, zr;
        start_level(8'd0, 8'd0, lat);
        zl = o_zone_left;
        zr = o_zone_right;
        tick();
        i_game_running = 1'b1;
        i_player_x     = zr;
        for (int i = 1; i <= HC; i++) begin
            tick();
            n_checks++;
            if (o_is_win !== (i == HC) || o_is_lose !== 1'b0) begin
                n_fail++;
                $display("FAIL win_hold: cycle %0d win=%b lose=%b, required win=%b lose=0", i, o_is_win, o_is_lose, i == HC);
            end
        end
        n_checks++;
        if (o_time_left !== TW'(LC - HC + 1) || o_zone_left !== zl || o_zone_right !== zr) begin
            n_fail++;
            $display("FAIL win_state: time=%0d left=%0d right=%0d, required %0d %0d %0d",
                     o_time_left, o_zone_left, o_zone_right, LC - HC + 1, zl, zr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (o_is_win !== 1'b0 || o_is_lose !== 1'b0) begin
                n_fail++;
                $display("FAIL done_quiet: win=%b lose=%b, required 0 0", o_is_win, o_is_lose);
            end
        end
        i_game_running = 1'b0;
        $display("test_win: done");
    endtask

    task automatic test_hold_restart();
        int lat;
        int cyc;
        logic [CW-1:0] zl, zr;
        start_level(8'd0, 8'd0, lat);
        zl = o_zone_left;
        zr = o_zone_right;
        tick();
        i_game_running = 1'b1;
        cyc = 0;
        // 5 inside, 1 outside, 9 inside: no win yet.
        for (int i = 1; i <= 15; i++) begin
            i_player_x = (i == 6) ? outside_x(zl, zr) : zl;
            tick();
            cyc++;
            n_checks++;
            if (o_is_win !== 1'b0 || o_is_lose !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_restart: cycle %0d win=%b lose=%b, required 0 0", cyc, o_is_win, o_is_lose);
            end
        end
        // Pause keeps both the timer and the hold count.
        i_game_running = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (o_time_left !== TW'(LC - 15) || o_is_win !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_pause: time=%0d win=%b, required %0d 0", o_time_left, o_is_win, LC - 15);
            end
        end
        i_game_running = 1'b1;
        tick();
        n_checks++;
        if (o_is_win !== 1'b1 || o_is_lose !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_resume_win: win=%b lose=%b, required 1 0", o_is_win, o_is_lose);
        end
        i_game_running = 1'b0;
        tick();
        $display("test_hold_restart: done");
    endtask

    task automatic test_lose(input int pause_at, input int pause_len);
        int lat;
        int run;
        start_level(8'd3, 8'd3, lat);
        i_player_x = outside_x(o_zone_left, o_zone_right);
        tick();
        run = 0;
        for (int i = 1; i <= LC + pause_len; i++) begin
            if (pause_len > 0 && run == pause_at && i <= pause_at + pause_len) begin
                i_game_running = 1'b0;
                tick();
                n_checks++;
                if (o_time_left !== TW'(LC - pause_at) || o_is_lose !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lose_pause: cycle %0d time=%0d lose=%b, required %0d 0", i, o_time_left, o_is_lose, LC - pause_at);
                end
            end else begin
                i_game_running = 1'b1;
                tick();
                run++;
                n_checks++;
                if (o_is_lose !== (run == LC) || o_is_win !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lose_timer: cycle %0d lose=%b win=%b, required lose=%b win=0", i, o_is_lose, o_is_win, run == LC);
                end
            end
        end
        n_checks++;
        if (o_time_left !== '0) begin
            n_fail++;
            $display("FAIL lose_time_zero: time=%0d, required 0", o_time_left);
        end
        tick();
        n_checks++;
        if (o_is_lose !== 1'b0) begin
            n_fail++;
            $display("FAIL lose_single: lose=%b on next cycle, required 0", o_is_lose);
        end
        i_game_running = 1'b0;
        $display("test_lose: pause_len=%0d done", pause_len);
    endtask

    task automatic test_coincide();
        int lat;
        logic [CW-1:0] zl, zr;
        start_level(8'd0, 8'd0, lat);
        zl = o_zone_left;
        zr = o_zone_right;
        tick();
        i_game_running = 1'b1;
        i_player_x = outside_x(zl, zr);
        for (int i = 0; i < LC - HC; i++) tick();
        n_checks++;
        if (o_time_left !== TW'(HC)) begin
            n_fail++;
            $display("FAIL coincide_time: time=%0d, required %0d", o_time_left, HC);
        end
        i_player_x = zl;
        for (int i = 0; i < HC; i++) tick();
        n_checks++;
        if (o_is_win !== 1'b1 || o_is_lose !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide_pulse: win=%b lose=%b, required 1 0", o_is_win, o_is_lose);
        end
        tick();
        n_checks++;
        if (o_is_win !== 1'b0 || o_is_lose !== 1'b0) begin
            n_fail++;
            $display("FAIL coincide_after: win=%b lose=%b, required 0 0", o_is_win, o_is_lose);
        end
        i_game_running = 1'b0;
        $display("test_coincide: done");
    endtask

    task automatic test_abort();
        int lat;
        logic [CW-1:0] zl;
        start_level(8'd0, 8'd0, lat);
        zl = o_zone_left;
        tick();
        i_game_running = 1'b1;
        i_player_x = zl;
        for (int i = 0; i < HC - 1; i++) tick();
        // This cycle would complete the hold; the request must win instead.
        i_regenerate_level = 1'b1;
        i_current_rating   = 8'd0;
        tick();
        i_regenerate_level = 1'b0;
        i_current_rating   = 8'd5;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            n_checks++;
            if (o_is_win !== 1'b0 || o_is_lose !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_pulse: cycle %0d win=%b lose=%b, required 0 0", k, o_is_win, o_is_lose);
            end
            if (o_ready === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
        n_checks++;
        if (lat < 3 || lat > 10) begin
            n_fail++;
            $display("FAIL abort_ready: latency %0d, required 3..10", lat);
        end
        n_checks++;
        if (int'(o_zone_right) - int'(o_zone_left) + 1 != 88) begin
            n_fail++;
            $display("FAIL abort_width: width %0d, required 88", int'(o_zone_right) - int'(o_zone_left) + 1);
        end
        i_game_running = 1'b0;
        tick();
        $display("test_abort: latency=%0d", lat);
    endtask

    task automatic test_async_reset();
        int lat;
        start_level(8'd0, 8'd0, lat);
        tick();
        i_game_running = 1'b1;
        i_player_x = o_zone_left;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_time_left !== '0 || o_zone_left !== '0 || o_zone_right !== '0 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: time=%0d left=%0d right=%0d ready=%b, required 0 0 0 0",
                     o_time_left, o_zone_left, o_zone_right, o_ready);
        end
        i_game_running = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start_level(8'd0, 8'd0, lat);
        n_checks++;
        if (lat < 3 || lat > 10 || o_time_left !== TW'(LC)) begin
            n_fail++;
            $display("FAIL reset_recover: latency=%0d time=%0d, required 3..10 and %0d", lat, o_time_left, LC);
        end
        $display("test_async_reset: done");
    endtask

    initial begin
        rst_n              = 1'b0;
        i_regenerate_level = 1'b0;
        i_current_rating   = '0;
        i_game_running     = 1'b0;
        i_player_x         = '0;
        #23;
        test_reset();
        tick();
        rst_n = 1'b1;
        tick();
        test_regen();
        test_width(8'd0,   8'd14,  16);
        test_width(8'd0,   8'd255, 16);
        test_width(8'd200, 8'd5,   88);
        test_win();
        test_hold_restart();
        test_lose(0, 0);
        test_lose(40, 20);
        test_coincide();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/safe_zone_ctrl.md
Name: safe_zone_ctrl

Overview:
- Generates each level's horizontal safe zone and judges the level. It is the producer end of the win/lose/ready/regenerate handshake with the game-state controller.
- On a regenerate request it places a pseudo-random zone whose width shrinks with the current rating, then pulses ready.
- While the game runs, it pulses win when the player stays inside the zone for HOLD_CYCLES running cycles, or lose when the level timer expires.

Parameters:
- COORD_WIDTH, 10, width of x coordinates.
- SCREEN_W, 640, horizontal extent; the zone must lie entirely in 0..SCREEN_W-1.
- RATING_WIDTH, 8, width of the rating input.
- ZONE_MAX_W, 128, zone width at rating 0.
- ZONE_MIN_W, 16, minimum zone width.
- SHRINK_STEP, 8, width reduction per rating point.
- HOLD_CYCLES, 50_000_000, consecutive running cycles inside the zone needed to win.
- LEVEL_CYCLES, 500_000_000, running cycles allowed per level; the timer is $clog2(LEVEL_CYCLES+1) bits wide.
- MAX_TRIES, 8, placement attempts before the fallback placement.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- i_regenerate_level  in  1  single-cycle request to build a new level
- i_current_rating  in  RATING_WIDTH  current rating
- i_game_running  in  1  high only while the level is running
- i_player_x  in  COORD_WIDTH  player x position
- o_ready  out  1  single-cycle pulse: level built
- o_is_win  out  1  single-cycle win pulse
- o_is_lose  out  1  single-cycle lose pulse
- o_zone_left  out  COORD_WIDTH  inclusive left edge of the zone
- o_zone_right  out  COORD_WIDTH  inclusive right edge of the zone
- o_time_left  out  $clog2(LEVEL_CYCLES+1)  remaining running cycles

Behaviour:
Reset values:
- State IDLE, all pulses 0, zone_left 0, zone_right 0, time_left 0, hold count 0.
- LFSR = 16'hACE1.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11.
- Advances every cycle in every state, so placement depends on request timing.
- It is never all-zero.

States:
- IDLE / DONE: wait for i_regenerate_level, then go to SIZE.
- SIZE (1 cycle): latch i_current_rating here, not on the request cycle, because the rating updates or clears on the same edge as the request.
  - width = max(ZONE_MIN_W, ZONE_MAX_W - rating*SHRINK_STEP).
  - Compute at full precision; no wrap when rating*SHRINK_STEP > ZONE_MAX_W.
  - Clear the try counter, then go to PLACE.
- PLACE: candidate = lfsr[COORD_WIDTH-1:0].
  - Accept if candidate + width <= SCREEN_W: zone_left = candidate, zone_right = candidate + width - 1.
  - On reject, increment the try counter. On the MAX_TRIES-th reject, use zone_left = SCREEN_W - width.
  - After accept or fallback, go to READY.
  - Zone outputs hold old values until accept or fallback.
- READY (1 cycle): o_ready = 1, time_left = LEVEL_CYCLES, hold = 0, then go to ARMED.
  - Minimum latency: request at cycle N gives o_ready at N+3.
  - Worst case: o_ready at N+2+MAX_TRIES.
- ARMED: on each cycle with i_game_running = 1, evaluate in this order:
  - inside = zone_left <= i_player_x <= zone_right.
  - If inside and hold == HOLD_CYCLES-1: o_is_win = 1 next cycle, go to DONE.
  - Else if time_left == 1: o_is_lose = 1 next cycle, time_left = 0, go to DONE.
  - Otherwise: time_left decrements; hold increments when inside, clears to 0 when outside.
  - If win and timer expiry coincide, win has priority; never assert both pulses.
  - Cycles with i_game_running = 0 (pause) freeze time_left and hold; hold is not cleared.
- i_regenerate_level in any state except SIZE/PLACE aborts the current level and goes to SIZE, with no win or lose pulse.
- i_regenerate_level during SIZE/PLACE is ignored.
- A win or lose pulse is emitted once per level; in DONE both stay 0.
- Reset mid-operation returns everything to the reset values immediately.

Test Plan (LEVEL_CYCLES=100, HOLD_CYCLES=10, defaults otherwise):
- Reset, then pulse regenerate with rating 0: o_ready exactly one cycle, between cycle 3 and cycle 10 after the request. zone_right - zone_left = 127, zone_right <= 639, time_left = 100.
- Rating 14 at the SIZE cycle: width = 16. Rating 255: width = 16, with no wrap.
- Running, player inside the zone for 10 cycles: one o_is_win pulse on the cycle after the 10th; no o_is_lose; zone edges stable.
- Player inside for 5 cycles, outside 1, inside 10: the win pulse arrives only after the second run, so the hold count restarts.
- Player always outside: o_is_lose pulses once after exactly 100 running cycles. With 20 paused cycles inserted, the pulse arrives 20 cycles later and time_left is frozen during the pause.
- Hold completes on the same cycle as time_left == 1: win only, no lose. Then regenerate mid-ARMED: no pulse, and a new o_ready follows.
